// File: rtl/smartbench_pkg.sv
// Shared encodings for the serial transmit path.
package smartbench_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: tick marks the last clk cycle of every BAUD_DIV-cycle bit.
module baud_tick #(
    parameter int unsigned BAUD_DIV = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Last cycle of the current bit period.
    assign tick = (cnt_q == CW'(BAUD_DIV - 1));

    // Count 0..BAUD_DIV-1, wrapping at bit boundaries; restart re-aligns on capture.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Asynchronous serial transmitter: start, LSB-first data, optional parity, 1-2 stop bits.
module uart_tx
    import smartbench_pkg::*;
#(
    parameter int unsigned BAUD_DIV  = 104,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_rdy,
    output logic                 tx_ack,
    output logic                 tx_line,
    output logic                 busy
);

    localparam int unsigned BCW = $clog2(DATA_BITS + 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 par_q, par_d;
    logic                 line_q, line_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 restart_c;
    logic                 tick_c;
    logic                 par_bit_c;

    baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart_c),
        .tick   (tick_c)
    );

    // Parity over the latched word, including the data bit currently on the line.
    assign par_bit_c = (PARITY == PARITY_ODD) ? ~(par_q ^ shift_q[0]) : (par_q ^ shift_q[0]);

    // Next-state and registered-output logic; every output is decided for the coming cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        line_d    = line_q;
        ack_d     = 1'b0;
        busy_d    = busy_q;
        restart_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                line_d = 1'b1;
                busy_d = 1'b0;
                if (tx_rdy) begin
                    state_d   = ST_START;
                    shift_d   = tx_data;
                    bit_cnt_d = '0;
                    par_d     = 1'b0;
                    line_d    = 1'b0;
                    ack_d     = 1'b1;
                    busy_d    = 1'b1;
                    restart_c = 1'b1;
                end
            end

            ST_START: begin
                if (tick_c) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    line_d    = shift_q[0];
                end
            end

            ST_DATA: begin
                if (tick_c) begin
                    par_d     = par_q ^ shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    line_d    = shift_q[1];
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            line_d  = par_bit_c;
                        end else begin
                            state_d = ST_STOP;
                            line_d  = 1'b1;
                        end
                    end
                end
            end

            ST_PARITY: begin
                if (tick_c) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                    line_d    = 1'b1;
                end
            end

            ST_STOP: begin
                if (tick_c) begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
                        // Back-to-back capture on the final stop cycle avoids an idle bit.
                        if (tx_rdy) begin
                            state_d   = ST_START;
                            shift_d   = tx_data;
                            bit_cnt_d = '0;
                            par_d     = 1'b0;
                            line_d    = 1'b0;
                            ack_d     = 1'b1;
                            restart_c = 1'b1;
                        end else begin
                            state_d   = ST_IDLE;
                            bit_cnt_d = '0;
                            line_d    = 1'b1;
                            busy_d    = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                line_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            line_q    <= 1'b1;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            line_q    <= line_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_line = line_q;
    assign tx_ack  = ack_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four configurations at BAUD_DIV=4 sharing one clock.
module tb_uart_tx;

    localparam int unsigned BD = 4;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic [3:0] rdy;
    logic [3:0] ack_w;
    logic [3:0] line_w;
    logic [3:0] busy_w;

    int n_checks;
    int n_fail;

    // Instance 0: no parity, 1 stop. 1: odd. 2: even. 3: no parity, 2 stop.
    uart_tx #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_none (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_rdy(rdy[0]),
        .tx_ack(ack_w[0]), .tx_line(line_w[0]), .busy(busy_w[0]));
    uart_tx #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_rdy(rdy[1]),
        .tx_ack(ack_w[1]), .tx_line(line_w[1]), .busy(busy_w[1]));
    uart_tx #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_rdy(rdy[2]),
        .tx_ack(ack_w[2]), .tx_line(line_w[2]), .busy(busy_w[2]));
    uart_tx #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_rdy(rdy[3]),
        .tx_ack(ack_w[3]), .tx_line(line_w[3]), .busy(busy_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic [7:0]  data;
        logic [11:0] frame;   // serial bit i of the frame sits at frame[i]
        int          nbits;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Raise tx_rdy on one instance and wait (bounded) for its tx_ack.
    task automatic send(input int inst, input logic [7:0] d, output bit ok);
        ok = 1'b0;
        tx_data = d;
        rdy[inst] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (ack_w[inst]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ack_seen", 32'(ok), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        send(v.inst, v.data, ok);
        rdy[v.inst] = 1'b0;
        if (!ok) return;
        for (int c = 0; c < v.nbits * int'(BD); c++) begin
            @(negedge clk);
            chk("frame_line", 32'(line_w[v.inst]), 32'(v.frame[c / int'(BD)]));
            chk("frame_busy", 32'(busy_w[v.inst]), 32'd1);
            chk("frame_ack", 32'(ack_w[v.inst]), 32'(c == 0));
        end
        @(negedge clk);
        chk("post_line", 32'(line_w[v.inst]), 32'd1);
        chk("post_busy", 32'(busy_w[v.inst]), 32'd0);
    endtask

    initial begin
        bit ok;
        int acks;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        rdy      = '0;
        tx_data  = '0;

        vecs[0] = '{0, 8'hA5, 12'h34A, 10};
        vecs[1] = '{2, 8'hA5, 12'h54A, 11};
        vecs[2] = '{1, 8'hA5, 12'h74A, 11};
        vecs[3] = '{2, 8'h01, 12'h602, 11};
        vecs[4] = '{1, 8'h01, 12'h402, 11};
        vecs[5] = '{2, 8'h00, 12'h400, 11};
        vecs[6] = '{1, 8'h00, 12'h600, 11};
        vecs[7] = '{0, 8'h3C, 12'h278, 10};

        // Reset state.
        #1;
        chk("rst_line", 32'(line_w), 32'hF);
        chk("rst_ack", 32'(ack_w), 32'h0);
        chk("rst_busy", 32'(busy_w), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back 0x00 then 0xFF with tx_rdy held high.
        send(0, 8'h00, ok);
        if (ok) begin
            tx_data = 8'hFF;
            acks = 0;
            for (int c = 0; c < 80; c++) begin
                logic [11:0] fr;
                @(negedge clk);
                fr = (c < 40) ? 12'h200 : 12'h3FE;
                chk("b2b_line", 32'(line_w[0]), 32'(fr[(c % 40) / int'(BD)]));
                chk("b2b_busy", 32'(busy_w[0]), 32'd1);
                chk("b2b_ack", 32'(ack_w[0]), 32'((c == 0) || (c == 40)));
                if (ack_w[0]) acks++;
                if (c == 40) rdy[0] = 1'b0;
            end
            chk("b2b_ack_count", 32'(acks), 32'd2);
            @(negedge clk);
            chk("b2b_idle_line", 32'(line_w[0]), 32'd1);
            chk("b2b_idle_busy", 32'(busy_w[0]), 32'd0);
        end
        rdy[0] = 1'b0;

        // Two stop bits: next capture no earlier than 44 cycles after the first.
        send(3, 8'h3C, ok);
        if (ok) begin
            logic [11:0] fr;
            fr = 12'h678;
            tx_data = 8'h81;
            for (int c = 0; c < 44; c++) begin
                @(negedge clk);
                chk("stop2_line", 32'(line_w[3]), 32'(fr[c / int'(BD)]));
                chk("stop2_ack", 32'(ack_w[3]), 32'(c == 0));
            end
            @(negedge clk);
            chk("stop2_next_ack", 32'(ack_w[3]), 32'd1);
            chk("stop2_next_start", 32'(line_w[3]), 32'd0);
        end
        rdy[3] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_w[3]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("stop2_drain", 32'(ok), 32'd1);

        // Mid-frame reset during data bit 3.
        send(0, 8'hA5, ok);
        rdy[0] = 1'b0;
        repeat (18) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_line", 32'(line_w[0]), 32'd1);
        chk("mrst_busy", 32'(busy_w[0]), 32'd0);
        chk("mrst_ack", 32'(ack_w[0]), 32'd0);
        @(negedge clk);
        chk("mrst_line_hold", 32'(line_w[0]), 32'd1);
        chk("mrst_ack_hold", 32'(ack_w[0]), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("mrst_after", 32'({line_w[0], busy_w[0], ack_w[0]}), 32'b100);
        end

        // Idle hold with toggling data and tx_rdy low.
        for (int c = 0; c < 100; c++) begin
            tx_data = 8'(c * 37);
            @(negedge clk);
            chk("idle_line", 32'(line_w), 32'hF);
            chk("idle_ack", 32'(ack_w), 32'h0);
            chk("idle_busy", 32'(busy_w), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
